// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture sequencer states and capture RAM geometry.
package la_pkg;

  localparam int CAP_ENTRIES = 384;
  localparam int CAP_AW      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/circ_ptr.sv
// Modulo-ENTRIES incrementing pointer with synchronous clear; clear wins over increment.
module circ_ptr
  import la_pkg::*;
#(
  parameter int ENTRIES = CAP_ENTRIES,
  parameter int AW      = CAP_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

  // Pointer register: wraps from the last entry back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Sequences one acquisition: fills the circular capture RAM, arms the trigger unit once
// enough pre-trigger history is held, keeps trig_pos post-trigger samples, then completes.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = CAP_ENTRIES,
  parameter int AW      = CAP_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          capture_done,
  input  logic          wrt_smpl,
  input  logic          triggered,
  input  logic [AW-1:0] trig_pos,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          armed,
  output logic          set_capture_done,
  output logic [AW-1:0] trace_end
);

  localparam logic [AW:0]   ENT_W  = (AW+1)'(ENTRIES);
  localparam logic [AW-1:0] TP_MAX = AW'(ENTRIES - 1);

  cap_state_t    state, state_nxt;
  logic [AW:0]   smpl_cnt, smpl_cnt_nxt;
  logic [AW-1:0] trig_cnt;
  logic [AW-1:0] tp;
  logic          trig_ok;
  logic          done_cond;
  logic          clr;
  logic          in_run;

  // A post-trigger depth that cannot fit in the RAM is limited to all-but-one entry.
  assign tp = ({1'b0, trig_pos} >= ENT_W) ? TP_MAX : trig_pos;

  // A trigger seen before arming is not a qualified trigger and is not counted.
  assign trig_ok   = triggered && armed;
  assign in_run    = (state == RUN);
  assign done_cond = in_run && trig_ok && (trig_cnt == tp);
  // Counters and the write pointer return to 0 in IDLE and on any exit caused by !run.
  assign clr       = (state == IDLE) || !run;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; dropping run aborts and beats completion in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run && !capture_done) state_nxt = RUN;
      RUN:     if (!run)                 state_nxt = IDLE;
               else if (done_cond)       state_nxt = DONE;
      DONE:    if (!run)                 state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Output logic: write the strobed sample unless this cycle completes the capture.
  always_comb begin
    we = in_run && wrt_smpl && !done_cond;
  end

  // Saturating sample count after this cycle's write, used by the arming compare.
  always_comb begin
    smpl_cnt_nxt = smpl_cnt;
    if (we && (smpl_cnt != ENT_W)) smpl_cnt_nxt = smpl_cnt + 1'b1;
  end

  // Sample and post-trigger counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_cnt <= '0;
      trig_cnt <= '0;
    end else if (clr) begin
      smpl_cnt <= '0;
      trig_cnt <= '0;
    end else begin
      smpl_cnt <= smpl_cnt_nxt;
      if (we && trig_ok) trig_cnt <= trig_cnt + 1'b1;
    end
  end

  // Armed, completion pulse and the recorded oldest-sample address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed            <= 1'b0;
      set_capture_done <= 1'b0;
      trace_end        <= '0;
    end else begin
      set_capture_done <= in_run && run && done_cond;
      if (in_run && run && !done_cond) armed <= ((smpl_cnt_nxt + {1'b0, tp}) >= ENT_W);
      else                             armed <= 1'b0;
      if (in_run && run && done_cond)  trace_end <= waddr;
    end
  end

  // Circular write pointer into the capture RAM.
  circ_ptr #(
    .ENTRIES (ENTRIES),
    .AW      (AW)
  ) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (we),
    .ptr   (waddr)
  );

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: behavioural acquisition model plus directed and random captures.
module tb_capture_ctrl;
  import la_pkg::*;

  localparam int E  = CAP_ENTRIES;
  localparam int AW = CAP_AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          capture_done = 1'b0;
  logic          wrt_smpl = 1'b0;
  logic          triggered = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          set_capture_done;
  logic [AW-1:0] trace_end;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int pulse_cnt = 0;

  // Model: phase 0 = idle, 1 = acquiring, 2 = finished.
  int m_phase = 0;
  int m_nwr   = 0;   // samples written in this acquisition (unbounded)
  int m_npost = 0;   // samples written after the qualified trigger
  int m_trace = 0;
  bit m_armed = 0;
  bit m_pulse = 0;

  capture_ctrl #(.ENTRIES(E), .AW(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .run              (run),
    .capture_done     (capture_done),
    .wrt_smpl         (wrt_smpl),
    .triggered        (triggered),
    .trig_pos         (trig_pos),
    .we               (we),
    .waddr            (waddr),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .trace_end        (trace_end)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  function automatic int tpc();
    return (int'(trig_pos) >= E) ? E - 1 : int'(trig_pos);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the acquisition rules, advanced on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    int  tp;
    bit  trig_ok, done, wr;
    if (!rst_n) begin
      m_phase = 0; m_nwr = 0; m_npost = 0; m_armed = 0; m_pulse = 0; m_trace = 0;
    end else begin
      tp      = tpc();
      trig_ok = triggered && m_armed;
      done    = (m_phase == 1) && trig_ok && (m_npost == tp);
      wr      = (m_phase == 1) && wrt_smpl && !done;
      m_pulse = 0;
      case (m_phase)
        0: begin
          m_armed = 0;
          if (run && !capture_done) begin m_phase = 1; m_nwr = 0; m_npost = 0; end
        end
        1: begin
          if (!run) begin
            m_phase = 0; m_nwr = 0; m_npost = 0; m_armed = 0;
          end else if (done) begin
            m_phase = 2; m_pulse = 1; m_trace = m_nwr % E; m_armed = 0;
          end else begin
            if (wr) begin
              m_nwr++;
              if (trig_ok) m_npost++;
            end
            m_armed = (((m_nwr < E) ? m_nwr : E) + tp) >= E;
          end
        end
        default: begin
          if (!run) begin m_phase = 0; m_nwr = 0; m_npost = 0; end
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int tp;
    bit done, exp_we;
    tp     = tpc();
    done   = (m_phase == 1) && triggered && m_armed && (m_npost == tp);
    exp_we = (m_phase == 1) && wrt_smpl && !done;
    chk("we", int'(we), int'(exp_we));
    chk("waddr", int'(waddr), m_nwr % E);
    chk("armed", int'(armed), int'(m_armed));
    chk("set_capture_done", int'(set_capture_done), int'(m_pulse));
    chk("trace_end", int'(trace_end), m_trace);
    if (we) we_cnt++;
    if (set_capture_done) pulse_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One acquisition; trigger raised once trig_after samples are held and the unit is armed.
  task automatic capture(input int tp, input int trig_after, input int period, input bit rnd,
                         input int abort_at, output int nwe, output int npulse,
                         output int arm_at, output bit aborted);
    int cyc = 0;
    int we0, p0;
    bit fin = 0;
    we0 = we_cnt; p0 = pulse_cnt;
    arm_at = -1; aborted = 0;
    trig_pos = AW'(tp); capture_done = 0; triggered = 0; run = 1;
    while (!fin && cyc < 20000) begin
      wrt_smpl = rnd ? ($urandom_range(0, period - 1) == 0) : ((cyc % period) == 0);
      step();
      cyc++;
      if (arm_at < 0 && armed) arm_at = m_nwr;
      if (m_phase == 1 && m_armed && m_nwr >= trig_after) triggered = 1;
      if (m_pulse) fin = 1;
      else if (abort_at >= 0 && cyc == abort_at) begin fin = 1; aborted = 1; end
    end
    if (!fin) chk("capture_timeout", 0, 1);
    triggered = 0;
    if (aborted) begin
      run = 0;
    end else begin
      capture_done = 1;
      wrt_smpl = 1;
      repeat (4) step();
      run = 0;
    end
    wrt_smpl = 0;
    repeat (2) step();
    nwe = we_cnt - we0;
    npulse = pulse_cnt - p0;
  endtask

  initial begin
    int nwe, npl, arm_at, tp, ta, thr, p0;
    bit ab;
    #1;
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_pulse", int'(set_capture_done), 0);
    chk("rst_trace_end", int'(trace_end), 0);
    repeat (2) step();
    rst_n = 1;
    step();

    // 1: trig_pos=128, strobe every cycle, trigger after 300 writes
    capture(128, 300, 1, 0, -1, nwe, npl, arm_at, ab);
    chk("t1_armed_at", arm_at, 256);
    chk("t1_writes", nwe, 428);
    chk("t1_pulses", npl, 1);
    chk("t1_trace_end", int'(trace_end), 44);

    // 2: trig_pos=10, trigger after 1000 writes (two wraps)
    capture(10, 1000, 1, 0, -1, nwe, npl, arm_at, ab);
    chk("t2_writes", nwe, 1010);
    chk("t2_pulses", npl, 1);
    chk("t2_trace_end", int'(trace_end), 242);

    // 3: trig_pos=0, trigger as soon as armed
    capture(0, 384, 1, 0, -1, nwe, npl, arm_at, ab);
    chk("t3_armed_at", arm_at, 384);
    chk("t3_writes", nwe, 384);
    chk("t3_pulses", npl, 1);
    chk("t3_trace_end", int'(trace_end), 0);

    // 4: one strobe in four, trig_pos=5, trigger after 400 writes
    capture(5, 400, 4, 0, -1, nwe, npl, arm_at, ab);
    chk("t4_writes", nwe, 405);
    chk("t4_pulses", npl, 1);
    chk("t4_trace_end", int'(trace_end), 21);

    // 5: run dropped in the very cycle completion would happen
    p0 = pulse_cnt;
    trig_pos = AW'(3); capture_done = 0; triggered = 0; run = 1; wrt_smpl = 1;
    begin
      int cyc = 0;
      bit hit = 0;
      while (!hit && cyc < 2000) begin
        step();
        cyc++;
        if (m_phase == 1 && m_armed && m_nwr >= 400) triggered = 1;
        if (m_phase == 1 && triggered && m_armed && m_npost == 3) hit = 1;
      end
      if (!hit) chk("t5_timeout", 0, 1);
    end
    run = 0;
    step();
    chk("t5_pulse", int'(set_capture_done), 0);
    chk("t5_waddr", int'(waddr), 0);
    chk("t5_armed", int'(armed), 0);
    triggered = 0; wrt_smpl = 0;
    repeat (3) step();
    chk("t5_no_pulse", pulse_cnt - p0, 0);

    // 6: asynchronous reset between clock edges in the middle of a capture
    trig_pos = AW'(50); capture_done = 0; run = 1; wrt_smpl = 1;
    repeat (100) step();
    #2;
    rst_n = 0;
    #1;
    chk("t6_we", int'(we), 0);
    chk("t6_waddr", int'(waddr), 0);
    chk("t6_armed", int'(armed), 0);
    chk("t6_pulse", int'(set_capture_done), 0);
    chk("t6_trace_end", int'(trace_end), 0);
    step();
    rst_n = 1;
    step();
    chk("t6_restart_waddr0", int'(waddr), 0);
    step();
    chk("t6_restart_waddr1", int'(waddr), 1);
    run = 0; wrt_smpl = 0;
    repeat (2) step();

    // Random captures: random depth (including clamped values), density, trigger point, aborts
    for (int i = 0; i < 6; i++) begin
      int abort_at;
      tp = $urandom_range(0, 511);
      ta = $urandom_range(0, 600);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 800) : -1;
      capture(tp, ta, $urandom_range(1, 3), 1, abort_at, nwe, npl, arm_at, ab);
      if (!ab) begin
        tp = (tp >= E) ? E - 1 : tp;
        thr = (ta > E - tp) ? ta : E - tp;
        chk("rnd_writes", nwe, thr + tp);
        chk("rnd_pulses", npl, 1);
        chk("rnd_trace_end", int'(trace_end), (thr + tp) % E);
      end else begin
        chk("rnd_abort_pulses", npl, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
